// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: redirect requests, icache line return, and the decode-side queue window.
interface ifetch_queue_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned DEQ_WIDTH   = 2
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned DC_W  = $clog2(DEQ_WIDTH + 1);

  logic                               if_valid;
  logic                               certain_branch_req;
  logic [XLEN-1:0]                    certain_branch_pc;
  logic                               rob_target_req;
  logic [XLEN-1:0]                    rob_target_pc;
  logic                               branch_pred_req;
  logic [XLEN-1:0]                    branch_pred_pc;
  logic                               branch_pred_slot;
  logic [63:0]                        Icache2proc_data;
  logic                               Icache2proc_data_valid;
  logic [DC_W-1:0]                    dispatch_count;
  logic [XLEN-1:0]                    proc2Icache_addr;
  logic [DEQ_WIDTH-1:0]               ifq_valid;
  logic [DEQ_WIDTH-1:0][31:0]         ifq_inst;
  logic [DEQ_WIDTH-1:0][XLEN-1:0]     ifq_pc;
  logic [CNT_W-1:0]                   ifq_count;

  modport master (
    output if_valid, certain_branch_req, certain_branch_pc, rob_target_req, rob_target_pc,
           branch_pred_req, branch_pred_pc, branch_pred_slot, Icache2proc_data,
           Icache2proc_data_valid, dispatch_count,
    input  proc2Icache_addr, ifq_valid, ifq_inst, ifq_pc, ifq_count
  );

  modport slave (
    input  if_valid, certain_branch_req, certain_branch_pc, rob_target_req, rob_target_pc,
           branch_pred_req, branch_pred_pc, branch_pred_slot, Icache2proc_data,
           Icache2proc_data_valid, dispatch_count,
    output proc2Icache_addr, ifq_valid, ifq_inst, ifq_pc, ifq_count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch with redirect arbitration and a circular instruction queue feeding decode.
// Decode-side outputs are flopped from the next-state queue image, so nothing from the inputs reaches them combinationally.
module ifetch_queue #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     QUEUE_DEPTH = 8,
  parameter int unsigned     DEQ_WIDTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic           clock,
  input logic           reset,
  ifetch_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  logic [XLEN-1:0]                pc_q, pc_d;
  logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  entry_t                         mem_q [QUEUE_DEPTH];
  entry_t                         mem_d [QUEUE_DEPTH];
  logic [DEQ_WIDTH-1:0]           valid_q, valid_d;
  logic [DEQ_WIDTH-1:0][31:0]     inst_q, inst_d;
  logic [DEQ_WIDTH-1:0][XLEN-1:0] ipc_q, ipc_d;

  logic            start_slot, last_slot, flush, enq, two;
  logic [1:0]      cand, n_enq;
  logic [CNT_W-1:0] free_slots;
  logic [XLEN-1:0] line_pc;

  // Redirect arbitration, all-or-nothing enqueue, and pointer/count update.
  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_d      = mem_q;
    valid_d    = '0;
    inst_d     = '0;
    ipc_d      = '0;

    start_slot = pc_q[2];
    line_pc    = {pc_q[XLEN-1:3], 3'b000};
    cand       = start_slot ? 2'd1 : 2'd2;
    free_slots = CNT_W'(QUEUE_DEPTH) - count_q;
    flush      = bus.certain_branch_req | bus.rob_target_req;
    enq        = bus.Icache2proc_data_valid & bus.if_valid & ~flush &
                 (free_slots >= CNT_W'(cand));
    // A taken prediction truncates the line after its slot.
    last_slot  = bus.branch_pred_req ? (start_slot | bus.branch_pred_slot) : 1'b1;
    two        = enq & ~start_slot & last_slot;
    n_enq      = enq ? (two ? 2'd2 : 2'd1) : 2'd0;

    if (enq) begin
      mem_d[tail_q] = '{pc:   {pc_q[XLEN-1:3], start_slot, 2'b00},
                        inst: start_slot ? bus.Icache2proc_data[63:32]
                                         : bus.Icache2proc_data[31:0]};
      if (two) begin
        mem_d[tail_q + PTR_W'(1)] = '{pc: line_pc + XLEN'(4), inst: bus.Icache2proc_data[63:32]};
      end
    end

    if (bus.certain_branch_req) begin
      pc_d = bus.certain_branch_pc & ALIGN_MASK;
    end else if (bus.rob_target_req) begin
      pc_d = bus.rob_target_pc & ALIGN_MASK;
    end else if (enq) begin
      pc_d = bus.branch_pred_req ? (bus.branch_pred_pc & ALIGN_MASK) : (line_pc + XLEN'(8));
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(bus.dispatch_count);
      tail_d  = tail_q + PTR_W'(n_enq);
      count_d = count_q - CNT_W'(bus.dispatch_count) + CNT_W'(n_enq);
    end

    for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
      valid_d[i] = CNT_W'(i) < count_d;
      inst_d[i]  = mem_d[head_d + PTR_W'(i)].inst;
      ipc_d[i]   = mem_d[head_d + PTR_W'(i)].pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= RESET_PC & ALIGN_MASK;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  // Queue payload needs no reset; occupancy gates its visibility.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign bus.proc2Icache_addr = {pc_q[XLEN-1:3], 3'b000};
  assign bus.ifq_valid        = valid_q;
  assign bus.ifq_inst         = inst_q;
  assign bus.ifq_pc           = ipc_q;
  assign bus.ifq_count        = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a reference queue/PC model predicts every decode-visible entry.
module tb_ifetch_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DEQ   = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [31:0] mpc;
  ent_t sbq [$];

  ifetch_queue_if #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .DEQ_WIDTH(DEQ)) bus ();

  ifetch_queue #(.XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .DEQ_WIDTH(DEQ), .RESET_PC(RESET_PC)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] line_of(input logic [31:0] a);
    if (a == 32'h0) return {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    return {a * 32'd3 + 32'h1234_0001, a * 32'd5 + 32'h8765_0000};
  endfunction

  task automatic idle();
    bus.if_valid               = 1'b0;
    bus.certain_branch_req     = 1'b0;
    bus.certain_branch_pc      = '0;
    bus.rob_target_req         = 1'b0;
    bus.rob_target_pc          = '0;
    bus.branch_pred_req        = 1'b0;
    bus.branch_pred_pc         = '0;
    bus.branch_pred_slot       = 1'b0;
    bus.Icache2proc_data_valid = 1'b0;
    bus.dispatch_count         = '0;
  endtask

  task automatic fetch();
    idle();
    bus.if_valid               = 1'b1;
    bus.Icache2proc_data_valid = 1'b1;
  endtask

  // One cycle: check outputs, pop dispatched entries, advance the model, cross the edge.
  task automatic step();
    logic [31:0]    la;
    logic [63:0]    d;
    logic [DEQ-1:0] ev;
    int             cnt0, s, last, dc;
    ent_t           e;
    la = {mpc[31:3], 3'b000};
    d  = line_of(la);
    bus.Icache2proc_data = d;
    dc = int'(bus.dispatch_count);
    chk("addr", 64'(bus.proc2Icache_addr), 64'(la));
    chk("count", 64'(bus.ifq_count), 64'(sbq.size()));
    ev = '0;
    for (int i = 0; i < DEQ; i++) ev[i] = (i < sbq.size());
    chk("valid", 64'(bus.ifq_valid), 64'(ev));
    for (int i = 0; i < dc; i++) begin
      chk("inst", 64'(bus.ifq_inst[i]), 64'(sbq[i].inst));
      chk("pc", 64'(bus.ifq_pc[i]), 64'(sbq[i].pc));
    end
    cnt0 = sbq.size();
    if (!rst_n) begin
      sbq.delete();
      mpc = RESET_PC;
    end else if (bus.certain_branch_req || bus.rob_target_req) begin
      sbq.delete();
      mpc = (bus.certain_branch_req ? bus.certain_branch_pc : bus.rob_target_pc) & ~32'h3;
    end else begin
      for (int i = 0; i < dc; i++) e = sbq.pop_front();
      if (bus.Icache2proc_data_valid && bus.if_valid) begin
        s = int'(mpc[2]);
        if (int'(DEPTH) - cnt0 >= (s == 1 ? 1 : 2)) begin
          last = bus.branch_pred_req ? (s | int'(bus.branch_pred_slot)) : 1;
          for (int k = s; k <= last; k++) begin
            e.inst = (k == 1) ? d[63:32] : d[31:0];
            e.pc   = la + 32'(4 * k);
            sbq.push_back(e);
          end
          mpc = bus.branch_pred_req ? (bus.branch_pred_pc & ~32'h3) : la + 32'h8;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.dispatch_count = 2'(sbq.size() < DEQ ? sbq.size() : DEQ);
      step();
    end
  endtask

  initial begin
    int mx;
    clk    = 1'b0;
    rst_n  = 1'b0;
    n_chk  = 0;
    n_pass = 0;
    mpc    = RESET_PC;
    idle();
    bus.Icache2proc_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First line after reset: both words enqueued, visible next cycle.
    fetch(); step();
    chk("tp1_valid", 64'(bus.ifq_valid), 64'(2'b11));
    chk("tp1_inst0", 64'(bus.ifq_inst[0]), 64'h0000_0000_AAAA_AAAA);
    chk("tp1_inst1", 64'(bus.ifq_inst[1]), 64'h0000_0000_BBBB_BBBB);
    chk("tp1_pc1", 64'(bus.ifq_pc[1]), 64'h4);
    chk("tp1_addr", 64'(bus.proc2Icache_addr), 64'h8);
    idle(); bus.dispatch_count = 2'd2; step();

    // All three redirects at once: EX branch wins and flushes.
    fetch();
    bus.certain_branch_req = 1'b1; bus.certain_branch_pc = 32'h1111_1111;
    bus.rob_target_req     = 1'b1; bus.rob_target_pc     = 32'h2222_2222;
    bus.branch_pred_req    = 1'b1; bus.branch_pred_pc    = 32'h3333_3333;
    step();
    chk("tp2_addr", 64'(bus.proc2Icache_addr), 64'h1111_1110);
    chk("tp2_count", 64'(bus.ifq_count), 64'h0);

    // Redirect into the upper slot of a line.
    idle(); bus.rob_target_req = 1'b1; bus.rob_target_pc = 32'h104; step();
    fetch(); step();
    chk("tp3_count", 64'(bus.ifq_count), 64'h1);
    chk("tp3_pc", 64'(bus.ifq_pc[0]), 64'h104);
    chk("tp3_addr", 64'(bus.proc2Icache_addr), 64'h108);
    idle(); bus.dispatch_count = 2'd1; step();

    // Fill with no dispatch; last line predicts into an odd slot.
    idle(); bus.certain_branch_req = 1'b1; bus.certain_branch_pc = 32'h0; step();
    for (int k = 0; k < 4; k++) begin
      fetch();
      if (k == 3) begin
        bus.branch_pred_req = 1'b1; bus.branch_pred_slot = 1'b1; bus.branch_pred_pc = 32'h44;
      end
      step();
      chk("tp4_fill", 64'(bus.ifq_count), 64'(2 * (k + 1)));
    end
    fetch(); step();
    chk("tp4_full", 64'(bus.ifq_count), 64'h8);
    chk("tp4_freeze", 64'(bus.proc2Icache_addr), 64'h40);
    idle(); bus.dispatch_count = 2'd1; step();
    fetch(); step();
    chk("tp4_odd7", 64'(bus.ifq_count), 64'h8);
    chk("tp4_odd_addr", 64'(bus.proc2Icache_addr), 64'h48);
    idle(); bus.dispatch_count = 2'd1; step();
    fetch(); step();
    chk("tp4_even7", 64'(bus.ifq_count), 64'h7);
    chk("tp4_even_addr", 64'(bus.proc2Icache_addr), 64'h48);
    drain();

    // Predicted-taken in slot 0 keeps only the first word.
    idle(); bus.certain_branch_req = 1'b1; bus.certain_branch_pc = 32'h200; step();
    fetch(); bus.branch_pred_req = 1'b1; bus.branch_pred_slot = 1'b0; bus.branch_pred_pc = 32'h400;
    step();
    chk("tp5_count", 64'(bus.ifq_count), 64'h1);
    chk("tp5_addr", 64'(bus.proc2Icache_addr), 64'h400);
    idle(); bus.dispatch_count = 2'd1; step();

    // Flush together with dispatch and a valid line.
    fetch(); step();
    fetch(); bus.dispatch_count = 2'd2;
    bus.certain_branch_req = 1'b1; bus.certain_branch_pc = 32'h80;
    step();
    chk("tp6_count", 64'(bus.ifq_count), 64'h0);
    chk("tp6_addr", 64'(bus.proc2Icache_addr), 64'h80);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.if_valid               = ($urandom_range(0, 99) < 85);
      bus.Icache2proc_data_valid = ($urandom_range(0, 99) < 70);
      bus.certain_branch_req     = ($urandom_range(0, 99) < 4);
      bus.certain_branch_pc      = 32'($urandom_range(0, 1023));
      bus.rob_target_req         = ($urandom_range(0, 99) < 4);
      bus.rob_target_pc          = 32'($urandom_range(0, 1023));
      bus.branch_pred_req        = ($urandom_range(0, 99) < 15);
      bus.branch_pred_pc         = 32'($urandom_range(0, 1023));
      bus.branch_pred_slot       = 1'($urandom_range(0, 1));
      mx = (sbq.size() < DEQ) ? sbq.size() : DEQ;
      bus.dispatch_count         = 2'($urandom_range(0, mx));
      step();
    end

    // Reset mid-stream.
    fetch(); step();
    fetch(); step();
    rst_n = 1'b0; fetch(); step();
    rst_n = 1'b1;
    chk("rst_count", 64'(bus.ifq_count), 64'h0);
    chk("rst_valid", 64'(bus.ifq_valid), 64'h0);
    chk("rst_addr", 64'(bus.proc2Icache_addr), 64'(RESET_PC));
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit with a decoupling instruction queue. Each cycle it presents an 8-byte-aligned fetch address to the icache and splits the returned 64-bit line into up to two 32-bit instructions. Incoming redirects are arbitrated in priority order: EX certain branch, then ROB target, then branch predictor. Fetched instructions are buffered in a circular queue, and decode drains up to DEQ_WIDTH instructions per cycle. It replaces the single-slot fetch stage between icache and decode.

## Interface
- XLEN, 32, address/PC width
- QUEUE_DEPTH, 8, queue entries; power of 2, ≥ 2
- DEQ_WIDTH, 2, instructions visible to decode per cycle; 1..QUEUE_DEPTH
- RESET_PC, 0, fetch PC after reset

- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low (asserted when 0)
- if_valid  in  1  fetch enable; 0 holds PC and suppresses enqueue
- certain_branch_req / certain_branch_pc  in  1 / XLEN  resolved taken branch from EX
- rob_target_req / rob_target_pc  in  1 / XLEN  ROB recovery redirect
- branch_pred_req / branch_pred_pc  in  1 / XLEN  predicted-taken redirect for the current line
- branch_pred_slot  in  1  slot (0 = bytes 3:0, 1 = bytes 7:4) of the predicted-taken instruction
- Icache2proc_data  in  64  line for proc2Icache_addr
- Icache2proc_data_valid  in  1  line valid this cycle (combinational hit)
- dispatch_count  in  $clog2(DEQ_WIDTH+1)  instructions decode accepts this cycle; ≤ valid count
- proc2Icache_addr  out  XLEN  {pc[XLEN-1:3], 3'b0}
- ifq_valid  out  DEQ_WIDTH  bit i set iff i < ifq_count
- ifq_inst  out  DEQ_WIDTH×32  entry head+i
- ifq_pc  out  DEQ_WIDTH×XLEN  PC of entry head+i
- ifq_count  out  $clog2(QUEUE_DEPTH+1)  occupancy

## Operation
- State: fetch pc register, QUEUE_DEPTH entries of {inst, pc}, head/tail pointers (mod QUEUE_DEPTH), and count.
- Redirect PCs have bits [1:0] forced to 0.
- Start slot is s = pc[2]. Candidate instructions run from slot s through slot 1: two when s = 0, one when s = 1.
- Predictor (only honoured when data_valid && if_valid):
  - The last slot enqueued is max(s, branch_pred_slot).
  - The next PC is branch_pred_pc.
- Enqueue condition: data_valid && if_valid && no flush && free slots (QUEUE_DEPTH − count at the start of the cycle) ≥ candidates. Enqueue is all-or-nothing.
  - On enqueue, the PC advances to pc_line + 8, or to branch_pred_pc when the predictor is taken.
  - Otherwise the PC holds. A prediction is ignored when its line is not enqueued.
- Flush (certain_branch_req or rob_target_req):
  - head, tail and count go to 0.
  - Same-cycle enqueue and dequeue are discarded.
  - pc takes the winning target.
- Priority: certain_branch > rob_target > branch_pred. Flush redirects act even when if_valid = 0.
- Dequeue: head advances by dispatch_count, and count -= dispatch_count. This is independent of enqueue in the same cycle.
- Dequeue has no bypass: an instruction is visible at ifq_* no earlier than the cycle after its enqueue.
- Pointers wrap modulo QUEUE_DEPTH. count saturates logically at QUEUE_DEPTH via the enqueue rule.

## Timing
- Reset (reset = 0 at posedge):
  - pc = RESET_PC.
  - count = 0 and head = tail = 0.
  - ifq_valid = 0 and ifq_count = 0.
  - proc2Icache_addr = RESET_PC aligned.
  - Reset overrides all redirects and takes effect even mid-operation.
- proc2Icache_addr is a register-derived output, changing only after a posedge.
- Redirect latency is 1 cycle: a request asserted in cycle N sets proc2Icache_addr to the target in cycle N+1.
- Fetch-to-decode latency is 1 cycle after the valid line.
- ifq_* and ifq_count are driven from registers only; there are no combinational paths from the inputs.
- Sustained throughput is 2 instructions/cycle when hits are aligned and the queue is not full.

## Test plan
- Reset, line at 0x0 valid = {0xBBBB_BBBB, 0xAAAA_AAAA}: next cycle ifq_valid = 2'b11, ifq_inst[0] = 0xAAAA_AAAA at pc 0x0, ifq_inst[1] = 0xBBBB_BBBB at pc 0x4, proc2Icache_addr = 0x8.
- All three requests in one cycle with targets 0x1111_1111 / 0x2222_2222 / 0x3333_3333: next cycle proc2Icache_addr = 0x1111_1110, ifq_count = 0.
- Redirect to 0x104: only the upper word is enqueued, with pc 0x104; then proc2Icache_addr = 0x108.
- Depth 8, dispatch_count = 0, streaming aligned hits:
  - ifq_count goes 2, 4, 6, 8, then holds, and proc2Icache_addr freezes.
  - With count = 7 and an aligned line, nothing is enqueued. With count = 7 and pc[2] = 1, one instruction is enqueued and count = 8.
- At pc 0x200, branch_pred_req with slot 0 and target 0x400: only 0x200 is enqueued, and the next proc2Icache_addr = 0x400.
- Flush in the same cycle as dispatch_count = 2 and a valid line: next cycle ifq_count = 0. Reset pulsed low mid-stream: all outputs return to reset values.
